// File: rtl/phase_bank_if.sv
// Bus bundle between the command deserializer, the phase bank and the PWM side.
interface phase_bank_if #(
  parameter int unsigned NUM_CHANNELS = 64,
  parameter int unsigned PHASE_W      = 8,
  parameter int unsigned ADDR_W       = 8
);
  logic                            en;
  logic [ADDR_W+PHASE_W-1:0]       phase_data;
  logic                            commit;
  logic                            sync;
  logic [NUM_CHANNELS*PHASE_W-1:0] phases;
  logic                            commit_pending;
  logic [15:0]                     frame_count;
  logic [7:0]                      drop_count;

  modport master (
    output en, phase_data, commit, sync,
    input  phases, commit_pending, frame_count, drop_count
  );

  modport slave (
    input  en, phase_data, commit, sync,
    output phases, commit_pending, frame_count, drop_count
  );
endinterface

// File: rtl/phase_bank.sv
// Double-buffered phase register bank: serial {channel, phase} writes fill a
// shadow bank, which is copied to the active bank on a commit aligned to sync.
module phase_bank #(
  parameter int unsigned NUM_CHANNELS   = 64,
  parameter int unsigned PHASE_W        = 8,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned BASE_CHANNEL   = 0,
  parameter int unsigned BROADCAST_ADDR = 2**ADDR_W-1
) (
  input logic         clk,
  input logic         rst,
  phase_bank_if.slave bus
);

  localparam int unsigned BANK_W = NUM_CHANNELS * PHASE_W;

  // The broadcast address must never alias a locally owned channel.
  if (BROADCAST_ADDR >= BASE_CHANNEL &&
      BROADCAST_ADDR < BASE_CHANNEL + NUM_CHANNELS) begin : g_bad_bcast
    $error("phase_bank: BROADCAST_ADDR lies inside the owned channel range");
  end

  typedef enum logic {ST_IDLE, ST_PENDING} state_e;

  state_e              state_q, state_d;
  logic [BANK_W-1:0]   shadow_q, shadow_d;
  logic [BANK_W-1:0]   active_q, active_d;
  logic [15:0]         frame_q, frame_d;
  logic [7:0]          drop_q, drop_d;
  logic                apply;
  logic                hit;
  logic                bcast;
  logic [ADDR_W-1:0]   addr;
  logic [PHASE_W-1:0]  phase;

  assign addr  = bus.phase_data[ADDR_W+PHASE_W-1:PHASE_W];
  assign phase = bus.phase_data[PHASE_W-1:0];

  // Commit FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Commit FSM: next state; a commit coinciding with sync applies immediately
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (bus.commit && !bus.sync) state_d = ST_PENDING;
      ST_PENDING: if (bus.sync)                state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Commit FSM: outputs
  always_comb begin
    apply              = bus.sync && (state_q == ST_PENDING || bus.commit);
    bus.commit_pending = (state_q == ST_PENDING);
  end

  // Write decode into the shadow bank; broadcast hits every entry
  always_comb begin
    shadow_d = shadow_q;
    hit      = 1'b0;
    bcast    = (32'(addr) == BROADCAST_ADDR);
    if (bus.en) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        if (bcast || 32'(addr) == BASE_CHANNEL + i) begin
          shadow_d[i*PHASE_W +: PHASE_W] = phase;
          hit = 1'b1;
        end
      end
    end
  end

  // Apply copies the pre-write shadow, so a concurrent write lands next frame
  always_comb begin
    active_d = active_q;
    frame_d  = frame_q;
    drop_d   = drop_q;
    if (apply) begin
      active_d = shadow_q;
      frame_d  = frame_q + 16'd1;
    end
    if (bus.en && !hit && drop_q != '1) drop_d = drop_q + 8'd1;
  end

  // Bank and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      frame_q  <= '0;
      drop_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      frame_q  <= frame_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.phases      = active_q;
  assign bus.frame_count = frame_q;
  assign bus.drop_count  = drop_q;

endmodule

// File: doc/phase_bank.md
Name: phase_bank

Overview:
- Multi-channel, double-buffered phase register bank for the transducer array.
- Decodes a serial stream of {channel, phase} words into a shadow bank. Copies the shadow bank to the active bank only on a frame commit, aligned to the PWM period sync pulse, so all channels update together and never mid-period.
- Sits between the host command deserializer and the per-channel PWM generators.
- Adds broadcast writes, frame-atomic commit, and status counters.

Parameters:
- NUM_CHANNELS, 64, number of channels held by this bank.
- PHASE_W, 8, phase word width in bits.
- ADDR_W, 8, channel address field width in bits.
- BASE_CHANNEL, 0, first global channel address owned by this bank.
- BROADCAST_ADDR, 2**ADDR_W-1, address that writes every shadow entry. Must lie outside [BASE_CHANNEL, BASE_CHANNEL+NUM_CHANNELS). An elaboration-time check fails otherwise.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  phase_data is valid this cycle.
- phase_data  in  ADDR_W+PHASE_W  [ADDR_W+PHASE_W-1:PHASE_W] is the channel address; [PHASE_W-1:0] is the phase.
- commit  in  1  single-cycle request to publish the shadow bank.
- sync  in  1  single-cycle PWM period boundary strobe.
- phases  out  NUM_CHANNELS*PHASE_W  active bank; channel i occupies [i*PHASE_W +: PHASE_W].
- commit_pending  out  1  a commit is waiting for sync.
- frame_count  out  16  number of applied commits, wraps.
- drop_count  out  8  number of out-of-range writes, saturating.

Behaviour:
- Reset (async assert, released synchronously upstream):
  - All shadow entries and all active entries = 0, so phases = 0.
  - commit_pending = 0, frame_count = 0, drop_count = 0.
- Write decode, on an en cycle; let a = address field:
  - a in [BASE_CHANNEL, BASE_CHANNEL+NUM_CHANNELS): shadow[a-BASE_CHANNEL] <= phase, written at the next edge.
  - a == BROADCAST_ADDR: every shadow entry <= phase.
  - Otherwise: no shadow change; drop_count increments, saturating at 255.
  - en low: no change.
  - Writes never touch phases directly.
- Commit state machine:
  - IDLE: commit with no sync moves to PENDING.
  - PENDING: sync applies the commit and returns to IDLE. Further commits are absorbed and frame_count is not double counted.
  - commit and sync in the same cycle while IDLE: the commit applies at that sync; commit_pending stays 0.
  - sync with no pending commit: no effect.
  - commit_pending = 1 exactly in PENDING.
- Apply: active <= shadow for all channels in one edge; frame_count <= frame_count+1, mod 2^16.
  - phases shows the new values the cycle after the applying sync edge.
- Simultaneous write and apply in the same cycle: active takes the pre-write shadow; the write lands in shadow for the next frame.
- Reset asserted mid-PENDING or mid-stream: everything clears immediately and the pending commit is lost.
- Latency:
  - Write to shadow: 1 cycle.
  - Shadow to phases: 1 cycle after the applying sync.
- No backpressure: a write is accepted every en cycle.

Test Plan:
- After reset, write ch3 = 0x5A (phase_data = 0x035A) -> phases ch3 stays 0x00; no commit issued, so commit_pending = 0.
- Write ch3 = 0x5A, pulse commit, wait 5 cycles, pulse sync -> commit_pending = 1 from the cycle after commit until sync. Cycle after sync: ch3 = 0x5A, all other channels 0, frame_count = 1.
- Broadcast 0xFF77, then commit+sync in the same cycle -> all 64 channels = 0x77 the next cycle; commit_pending never rises; frame_count = 1.
- Pre-load shadow ch0 = 0x11; in the cycle sync applies a pending commit, write ch0 = 0x22 -> active ch0 = 0x11. A second commit+sync gives ch0 = 0x22; frame_count = 2.
- BASE_CHANNEL = 64, NUM_CHANNELS = 64: write address 0x10 x300 -> drop_count = 255 (saturated), phases unchanged. Write address 0x50 = 0x33, commit, sync -> local ch16 = 0x33.
- Assert rst asynchronously (mid-clock) while commit_pending = 1 and phases are nonzero -> all outputs 0 immediately. After release, a sync alone leaves phases = 0 and frame_count = 0.
